// File: rtl/conv_seq_pkg.sv
// Shared types and size helpers for the 3x3 conv layer sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_W    = 2'd1,
    STREAM_PX = 2'd2,
    WAIT_OUT  = 2'd3
  } seq_state_e;

  function automatic int unsigned w_total(input int unsigned kernel, input int unsigned ch_in);
    return kernel * kernel * ch_in;
  endfunction

  function automatic int unsigned p_total(input int unsigned width, input int unsigned height,
                                          input int unsigned ch_in);
    return width * height * ch_in;
  endfunction

  function automatic int unsigned o_total(input int unsigned width, input int unsigned height);
    return width * height;
  endfunction

  // Bits needed to hold 0..total inclusive.
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total < 1) ? 1 : $clog2(total + 1);
  endfunction

  // Bits needed to index 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_seq_term_cnt.sv
// Up-counter with clear, increment, optional saturation and a terminal-count flag.
module conv_seq_term_cnt #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LAST     = 15,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             last_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over increment; a saturating counter ignores increments at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(SATURATE && last_o)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == WIDTH'(LAST));

endmodule

// File: rtl/conv_3x3_layer_sequencer.sv
// Per-output-channel scheduler for a 3x3 conv layer: weight load, pixel stream,
// then wait for every output pixel before the next channel.
module conv_3x3_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IMAGE_WIDTH     = 16,
  parameter int unsigned IMAGE_HEIGHT    = 16,
  parameter int unsigned CHANNEL_NUM_IN  = 256,
  parameter int unsigned CHANNEL_NUM_OUT = 256,
  parameter int unsigned KERNEL          = 3
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      w_valid,
  input  logic [DATA_WIDTH-1:0]                     w_data,
  output logic                                      w_ready,
  input  logic                                      p_valid,
  input  logic [DATA_WIDTH-1:0]                     p_data,
  output logic                                      p_ready,
  output logic                                      valid_weight_out,
  output logic [DATA_WIDTH-1:0]                     weight_out,
  output logic                                      valid_pxl_out,
  output logic [DATA_WIDTH-1:0]                     pxl_out,
  input  logic                                      conv_valid,
  output logic [idx_width(CHANNEL_NUM_OUT)-1:0]     ch_idx,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err
);

  localparam int unsigned W_TOTAL = w_total(KERNEL, CHANNEL_NUM_IN);
  localparam int unsigned P_TOTAL = p_total(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_IN);
  localparam int unsigned O_TOTAL = o_total(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int unsigned W_CW    = cnt_width(W_TOTAL);
  localparam int unsigned P_CW    = cnt_width(P_TOTAL);
  localparam int unsigned O_CW    = cnt_width(O_TOTAL);
  localparam int unsigned CH_W    = idx_width(CHANNEL_NUM_OUT);

  seq_state_e            state_q;
  logic                  busy_q, done_q, err_q;
  logic                  vw_q, vp_q;
  logic [DATA_WIDTH-1:0] wd_q, pd_q;

  logic [W_CW-1:0] w_cnt;
  logic [P_CW-1:0] p_cnt;
  logic [O_CW-1:0] o_cnt;
  logic [CH_W-1:0] ch_cnt;
  logic            w_last, p_last, o_last, ch_last;
  logic            w_xfer, p_xfer, o_near, ch_exit, err_set;
  logic            in_idle, o_inc;
  logic            unused_cnt;

  assign in_idle = (state_q == IDLE);
  assign w_ready = (state_q == LOAD_W);
  assign p_ready = (state_q == STREAM_PX);
  assign w_xfer  = w_valid & w_ready;
  assign p_xfer  = p_valid & p_ready;
  assign o_inc   = conv_valid & ((state_q == STREAM_PX) | (state_q == WAIT_OUT));
  assign o_near  = (o_cnt == O_CW'(O_TOTAL - 1));

  // The final output pulse and the channel exit share one edge.
  assign ch_exit = (state_q == WAIT_OUT) & (o_last | (conv_valid & o_near));
  assign err_set = conv_valid & ((state_q == IDLE) | (state_q == LOAD_W) | o_last);
  assign unused_cnt = ^{w_cnt, p_cnt};

  conv_seq_term_cnt #(.WIDTH(W_CW), .LAST(W_TOTAL - 1), .SATURATE(1'b0)) u_w_cnt (
    .clk(clk), .reset(reset), .clr_i(in_idle | (w_xfer & w_last)), .inc_i(w_xfer),
    .cnt_o(w_cnt), .last_o(w_last)
  );

  conv_seq_term_cnt #(.WIDTH(P_CW), .LAST(P_TOTAL - 1), .SATURATE(1'b0)) u_p_cnt (
    .clk(clk), .reset(reset), .clr_i(in_idle | (p_xfer & p_last)), .inc_i(p_xfer),
    .cnt_o(p_cnt), .last_o(p_last)
  );

  conv_seq_term_cnt #(.WIDTH(O_CW), .LAST(O_TOTAL), .SATURATE(1'b1)) u_o_cnt (
    .clk(clk), .reset(reset), .clr_i(in_idle | ch_exit), .inc_i(o_inc),
    .cnt_o(o_cnt), .last_o(o_last)
  );

  conv_seq_term_cnt #(.WIDTH(CH_W), .LAST(CHANNEL_NUM_OUT - 1), .SATURATE(1'b0)) u_ch_cnt (
    .clk(clk), .reset(reset), .clr_i(in_idle | (ch_exit & ch_last)), .inc_i(ch_exit & ~ch_last),
    .cnt_o(ch_cnt), .last_o(ch_last)
  );

  // Phase sequencing with registered busy/done/err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_W;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        LOAD_W:    if (w_xfer && w_last) state_q <= STREAM_PX;
        STREAM_PX: if (p_xfer && p_last) state_q <= WAIT_OUT;
        WAIT_OUT: begin
          if (ch_exit) begin
            if (ch_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD_W;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (err_set) err_q <= 1'b1;
    end
  end

  // Forwarding registers hold the last accepted word between transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vw_q <= 1'b0;
      vp_q <= 1'b0;
      wd_q <= '0;
      pd_q <= '0;
    end else begin
      vw_q <= w_xfer;
      vp_q <= p_xfer;
      if (w_xfer) wd_q <= w_data;
      if (p_xfer) pd_q <= p_data;
    end
  end

  assign valid_weight_out = vw_q;
  assign weight_out       = wd_q;
  assign valid_pxl_out    = vp_q;
  assign pxl_out          = pd_q;
  assign ch_idx           = ch_cnt;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: tb/tb_conv_3x3_layer_sequencer.sv
// Randomised bench for conv_3x3_layer_sequencer against a count-based layer model.
module tb_conv_3x3_layer_sequencer;

  localparam int DW = 32, IW = 4, IH = 4, CIN = 2, COUT = 2, K = 3;
  localparam int WT = K * K * CIN;
  localparam int PT = IW * IH * CIN;
  localparam int OT = IW * IH;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_STREAM = 2, PH_WAIT = 3;
  localparam int CYC_MAX = 3000;

  logic          clk = 1'b0;
  logic          reset, start, w_valid, p_valid, conv_valid;
  logic [DW-1:0] w_data, p_data, weight_out, pxl_out;
  logic          w_ready, p_ready, valid_weight_out, valid_pxl_out, busy, done, err;
  logic [0:0]    ch_idx;

  conv_3x3_layer_sequencer #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
    .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .KERNEL(K)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .valid_weight_out(valid_weight_out), .weight_out(weight_out),
    .valid_pxl_out(valid_pxl_out), .pxl_out(pxl_out),
    .conv_valid(conv_valid), .ch_idx(ch_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int n_wout, n_pout, n_done;

  // Layer model: progress counts within the current channel.
  bit            m_active, m_err;
  int            m_ch, m_w, m_p, m_o;
  bit            e_vw, e_vp, e_done;
  logic [DW-1:0] e_wd, e_pd;

  // Source contents for one layer and the next word each source offers.
  logic [DW-1:0] w_src[$], p_src[$];
  int            w_pos, p_pos;
  int            w_gap, p_gap, cv_mode;
  bit            inj_en, inj_load_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int phase();
    if (!m_active) return PH_IDLE;
    if (m_w < WT) return PH_LOAD;
    if (m_p < PT) return PH_STREAM;
    return PH_WAIT;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_err = 1'b0;
    m_ch = 0; m_w = 0; m_p = 0; m_o = 0;
    e_vw = 1'b0; e_vp = 1'b0; e_done = 1'b0;
    e_wd = '0; e_pd = '0;
  endtask

  task automatic new_sources();
    w_src.delete();
    p_src.delete();
    for (int i = 0; i < COUT * WT; i++) w_src.push_back($urandom());
    for (int i = 0; i < COUT * PT; i++) p_src.push_back($urandom());
    w_pos = 0;
    p_pos = 0;
  endtask

  // Apply one clock's worth of inputs to the model.
  task automatic model_step();
    int ph;
    bit o_full, exit_ch;
    ph      = phase();
    o_full  = (m_o == OT);
    exit_ch = 1'b0;
    e_vw = 1'b0; e_vp = 1'b0; e_done = 1'b0;
    case (ph)
      PH_IDLE: begin
        if (start) begin
          m_active = 1'b1; m_err = 1'b0;
          m_ch = 0; m_w = 0; m_p = 0; m_o = 0;
        end
      end
      PH_LOAD: begin
        if (w_valid) begin e_vw = 1'b1; e_wd = w_data; m_w++; w_pos++; end
      end
      PH_STREAM: begin
        if (p_valid) begin e_vp = 1'b1; e_pd = p_data; m_p++; p_pos++; end
        if (conv_valid && !o_full) m_o++;
      end
      default: begin
        if (o_full) exit_ch = 1'b1;
        else if (conv_valid) begin m_o++; exit_ch = (m_o == OT); end
      end
    endcase
    if (conv_valid && (ph == PH_IDLE || ph == PH_LOAD || o_full)) m_err = 1'b1;
    if (exit_ch) begin
      m_o = 0; m_w = 0; m_p = 0;
      if (m_ch < COUT - 1) m_ch++;
      else begin m_ch = 0; m_active = 1'b0; e_done = 1'b1; end
    end
  endtask

  task automatic check_outputs();
    int ph;
    ph = phase();
    chk("busy", 64'(busy), 64'(m_active));
    chk("w_ready", 64'(w_ready), 64'(ph == PH_LOAD));
    chk("p_ready", 64'(p_ready), 64'(ph == PH_STREAM));
    chk("ready_exclusive", 64'(w_ready & p_ready), 64'(0));
    chk("valid_weight_out", 64'(valid_weight_out), 64'(e_vw));
    chk("weight_out", 64'(weight_out), 64'(e_wd));
    chk("valid_pxl_out", 64'(valid_pxl_out), 64'(e_vp));
    chk("pxl_out", 64'(pxl_out), 64'(e_pd));
    chk("done", 64'(done), 64'(e_done));
    chk("err", 64'(err), 64'(m_err));
    chk("ch_idx", 64'(ch_idx), 64'(m_ch));
    if (valid_weight_out === 1'b1) n_wout++;
    if (valid_pxl_out === 1'b1) n_pout++;
    if (done === 1'b1) n_done++;
  endtask

  task automatic drive_inputs();
    int ph;
    ph = phase();
    w_valid = (w_pos < w_src.size()) && ($urandom_range(99) >= w_gap);
    w_data  = w_valid ? w_src[w_pos] : DW'($urandom());
    p_valid = (p_pos < p_src.size()) && ($urandom_range(99) >= p_gap);
    p_data  = p_valid ? p_src[p_pos] : DW'($urandom());
    conv_valid = 1'b0;
    if (m_o < OT) begin
      case (cv_mode)
        0:       conv_valid = (ph == PH_WAIT);
        1:       conv_valid = (ph == PH_STREAM || ph == PH_WAIT) && ($urandom_range(1) == 1);
        default: conv_valid = (ph == PH_STREAM || ph == PH_WAIT);
      endcase
    end
    if (inj_en && ph == PH_LOAD && m_ch == 0 && m_w == 5 && !inj_load_done) begin
      conv_valid = 1'b1;
      inj_load_done = 1'b1;
    end
    if (inj_en && ph == PH_WAIT && m_o == OT) conv_valid = 1'b1;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; w_valid = 1'b0; p_valid = 1'b0; conv_valid = 1'b0;
      tick();
    end
  endtask

  task automatic async_reset();
    start = 1'b0; w_valid = 1'b0; p_valid = 1'b0; conv_valid = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
  endtask

  // Starts a layer from IDLE (possibly in a done cycle) and follows it to its end.
  task automatic run_layer(input int wg, input int pg, input int mode, input bit mid_start,
                           input bit inj, input int rst_pix);
    int cyc;
    bit aborted;
    cyc = 0;
    aborted = 1'b0;
    w_gap = wg; p_gap = pg; cv_mode = mode;
    inj_en = inj; inj_load_done = 1'b0;
    n_wout = 0; n_pout = 0; n_done = 0;
    new_sources();
    drive_inputs();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (m_active && cyc < CYC_MAX && !aborted) begin
      drive_inputs();
      start = mid_start && ($urandom_range(3) == 0);
      tick();
      cyc++;
      if (rst_pix >= 0 && m_active && m_ch == 1 && m_p == rst_pix && phase() == PH_STREAM) begin
        async_reset();
        aborted = 1'b1;
      end
    end
    start = 1'b0;
    if (m_active) begin
      n_checks++;
      n_fail++;
      $error("FAIL layer_timeout: observed busy=%0b after %0d cycles, expected done", busy, cyc);
    end else if (!aborted) begin
      chk("weights_forwarded", 64'(n_wout), 64'(COUT * WT));
      chk("pixels_forwarded", 64'(n_pout), 64'(COUT * PT));
      chk("done_pulses", 64'(n_done), 64'(1));
      chk("err_at_end", 64'(err), 64'(inj));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    w_valid = 1'b0; p_valid = 1'b0; conv_valid = 1'b0;
    w_data = '0; p_data = '0;
    model_reset();
    n_wout = 0; n_pout = 0; n_done = 0;
    w_gap = 0; p_gap = 0; cv_mode = 0; inj_en = 1'b0; inj_load_done = 1'b0;
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);

    // Full layer with always-valid sources and outputs only in WAIT_OUT.
    run_layer(0, 0, 0, 1'b0, 1'b0, -1);
    idle_cycles(3);

    // Stalling sources, random output pulses, stray starts while busy.
    run_layer(50, 50, 1, 1'b1, 1'b0, -1);
    // Next layer launched by a start in the done cycle.
    run_layer(30, 30, 0, 1'b0, 1'b0, -1);
    idle_cycles(3);

    // conv_valid during LOAD_W and a surplus pulse in WAIT_OUT.
    run_layer(0, 20, 2, 1'b0, 1'b1, -1);
    idle_cycles(3);

    // Asynchronous reset after pixel 10 of channel 1, then a clean restart.
    run_layer(20, 20, 1, 1'b0, 1'b0, 10);
    idle_cycles(2);
    run_layer(0, 0, 0, 1'b0, 1'b0, -1);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
